ahb_bus_decoder_mux: RTL and testbench
======================================

// Module: ahb_bus_decoder_mux
// PURPOSE
// - Parametrised AHB-Lite decoder plus slave-to-master response mux for NUM_SLAVES regions.
// - Decodes HADDR during the address phase and registers the selection for the data phase.
// - Muxes HRDATA/HREADYOUT/HRESP back to the master.
// - Contains a built-in default slave that returns a two-cycle ERROR for unmapped accesses.
// - Sits between the single AHB master and the slave fabric (SRAM, APB bridge, ...).
// PARAMETERS
// - NUM_SLAVES  4                          number of decoded slave regions (1..16)
// - ADDR_W      32                         HADDR width
// - DATA_W      32                         HRDATA width
// - SLV_BASE    {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}  packed NUM_SLAVES*ADDR_W region bases, slot i at [i*ADDR_W +: ADDR_W]
// - SLV_MASK    {4{32'hFFFF_0000}}         packed NUM_SLAVES*ADDR_W region masks (1 = compared bit)
// PORTS
// - HCLK          in   1                    bus clock
// - HRESET        in   1                    synchronous reset, active-high
// - HADDR         in   ADDR_W               master address
// - HTRANS        in   2                    master transfer type
// - HSEL          out  NUM_SLAVES           address-phase slave selects
// - HRDATA_S      in   NUM_SLAVES*DATA_W    packed slave read data
// - HREADYOUT_S   in   NUM_SLAVES           per-slave HREADYOUT
// - HRESP_S       in   NUM_SLAVES           per-slave HRESP
// - HRDATA        out  DATA_W               muxed read data to master
// - HREADY        out  1                    muxed ready; also fed back to all slaves
// - HRESP         out  1                    muxed response (0=OKAY, 1=ERROR)
// BEHAVIOUR
// - valid = !HRESET && HTRANS[1] (NONSEQ=2'b10 / SEQ=2'b11). IDLE and BUSY select nothing.
// - match[i] = ((HADDR & MASK_i) == (BASE_i & MASK_i)).
// - Overlapping regions: lowest index wins.
// - HSEL: combinational, one-hot or zero. HSEL[i] = valid && lowest match is i.
// - def_sel = valid && no match. It drives no port; it selects the internal default slave.
// - Data-phase select dsel: register of NUM_SLAVES+1 bits (slots + default).
//   - Loaded with {def_sel, HSEL} on a rising HCLK when HREADY=1.
//   - Holds while HREADY=0.
//   - Reset value: all zero (no slave).
// - Response mux, combinational from dsel and slave inputs:
//   - dsel[i] set: HRDATA = HRDATA_S slot i; HREADY = HREADYOUT_S[i]; HRESP = HRESP_S[i].
//   - dsel all zero: HRDATA = 0, HREADY = 1, HRESP = 0.
//   - Default slave selected: HRDATA = 0; HREADY and HRESP come from the default-slave FSM.
// - Default-slave FSM, states D_IDLE, D_ERR1, D_ERR2.
//   - D_IDLE -> D_ERR1 when HREADY && def_sel.
//   - D_ERR1 -> D_ERR2 unconditionally. Drives HREADY=0, HRESP=1.
//   - D_ERR2 drives HREADY=1, HRESP=1.
//   - D_ERR2 -> D_ERR1 if def_sel in that cycle (back-to-back unmapped access); else -> D_IDLE.
// - Latency:
//   - Mapped access: the response is the slave's own; the block adds no wait state.
//   - Unmapped access: data phase is exactly 2 cycles (ERROR, ERROR).
// - Reset values: HSEL=0, HREADY=1, HRESP=0, HRDATA=0, dsel=0, FSM=D_IDLE.
// - Reset mid-transfer: HRESET dominates on the next edge; any pending data phase is dropped.
// - A slave stalled with HREADYOUT_S=0 holds dsel. New address-phase HSEL still tracks HADDR.
// CONFIGURATION
// - Macro DEC_ERR_LOG_EN.
// - Defined: adds output ports err_count (16) and err_addr (ADDR_W).
//   - err_count increments on each D_IDLE/D_ERR2 -> D_ERR1 transition and saturates at 16'hFFFF.
//   - err_addr captures HADDR of that unmapped access.
//   - Both reset to 0.
// - Undefined: neither port exists and there is no logging logic. All other behaviour is identical.
// TESTING
// - Decode + mux: NONSEQ to 0x1000_0040 -> HSEL=4'b0010 that cycle.
//   Next cycle HRDATA = slot-1 data, HREADY = HREADYOUT_S[1].
// - IDLE gating: HTRANS=00 with HADDR=0x0000_0000 -> HSEL=0.
//   Next data phase HREADY=1, HRESP=0, HRDATA=0.
// - Unmapped: NONSEQ to 0x8000_0000 -> HSEL=0.
//   Next cycles (HREADY,HRESP) = (0,1) then (1,1), then FSM in D_IDLE.
// - Wait states: slave 2 holds HREADYOUT_S[2]=0 for 3 cycles.
//   HREADY=0 for 3 cycles; dsel unchanged; next transfer to slave 0 is accepted only when HREADY=1.
// - Reset: assert HRESET during D_ERR1 -> next edge HREADY=1, HRESP=0, dsel=0, FSM=D_IDLE.
// - Back-to-back unmapped, with DEC_ERR_LOG_EN: two unmapped NONSEQs
//   -> (0,1),(1,1),(0,1),(1,1); err_count=2; err_addr = second HADDR.

Source files
------------

// File: rtl/ahb_bus_decoder_mux.sv
// ---------------------------------------------------------------------------
// ahb_bus_decoder_mux
// AHB-Lite address decoder plus slave-to-master response multiplexer for
// NUM_SLAVES mask/base regions, with a built-in default slave that answers
// unmapped transfers with a two-cycle ERROR response.
//
// Ports:
//   HCLK, HRESET        bus clock, synchronous active-high reset
//   HADDR, HTRANS       master address-phase signals
//   HSEL                combinational one-hot (or zero) slave selects
//   HRDATA_S            packed slave read data, slot i at [i*DATA_W +: DATA_W]
//   HREADYOUT_S/HRESP_S per-slave ready / response
//   HRDATA/HREADY/HRESP muxed response to the master (HREADY also to slaves)
//
// Optional feature (macro DEC_ERR_LOG_EN): adds err_count (saturating count
// of unmapped transfers accepted) and err_addr (HADDR of the latest one).
// ---------------------------------------------------------------------------
module ahb_bus_decoder_mux #(
    parameter int                             NUM_SLAVES = 4,
    parameter int                             ADDR_W     = 32,
    parameter int                             DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_BASE   = {32'h3000_0000, 32'h2000_0000,
                                                            32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_MASK   = {4{32'hFFFF_0000}}
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [ADDR_W-1:0]            HADDR,
    input  logic [1:0]                   HTRANS,
    output logic [NUM_SLAVES-1:0]        HSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]        HRESP_S,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic                         HRESP
`ifdef DEC_ERR_LOG_EN
    ,
    output logic [15:0]                  err_count,
    output logic [ADDR_W-1:0]            err_addr
`endif
);

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } dstate_t;

    dstate_t                 state_r;
    dstate_t                 state_nxt_s;
    logic                    valid_s;
    logic [NUM_SLAVES-1:0]   match_s;
    logic [NUM_SLAVES-1:0]   lowest_s;
    logic                    def_sel_s;
    logic [NUM_SLAVES:0]     dsel_r;
    logic                    dflt_ready_s;
    logic                    dflt_resp_s;
    logic [DATA_W-1:0]       rdata_s;
    logic                    ready_s;
    logic                    resp_s;
    logic                    unused_htrans_s;

    // HTRANS[0] only distinguishes NONSEQ/SEQ and IDLE/BUSY; neither matters here.
    assign unused_htrans_s = HTRANS[0];
    assign valid_s         = !HRESET && HTRANS[1];

    // Region compare for every slot.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            match_s[i] = ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                          (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]));
        end
    end

    // Isolating the lowest set bit gives lowest-index priority on overlap.
    assign lowest_s  = match_s & (~match_s + NUM_SLAVES'(1'b1));
    assign HSEL      = valid_s ? lowest_s : '0;
    assign def_sel_s = valid_s && (match_s == '0);

    // Default-slave next state and its HREADY/HRESP contribution.
    always_comb begin
        state_nxt_s  = state_r;
        dflt_ready_s = 1'b1;
        dflt_resp_s  = 1'b0;
        case (state_r)
            D_IDLE: begin
                if (HREADY && def_sel_s) begin
                    state_nxt_s = D_ERR1;
                end else begin
                    state_nxt_s = D_IDLE;
                end
            end
            D_ERR1: begin
                state_nxt_s  = D_ERR2;
                dflt_ready_s = 1'b0;
                dflt_resp_s  = 1'b1;
            end
            D_ERR2: begin
                dflt_ready_s = 1'b1;
                dflt_resp_s  = 1'b1;
                // HREADY is high in this state, so a new unmapped access is accepted now.
                if (def_sel_s) begin
                    state_nxt_s = D_ERR1;
                end else begin
                    state_nxt_s = D_IDLE;
                end
            end
            default: begin
                state_nxt_s = D_IDLE;
            end
        endcase
    end

    // Response mux driven by the registered data-phase select.
    always_comb begin
        rdata_s = '0;
        ready_s = 1'b1;
        resp_s  = 1'b0;
        if (dsel_r[NUM_SLAVES]) begin
            ready_s = dflt_ready_s;
            resp_s  = dflt_resp_s;
        end else if (dsel_r[NUM_SLAVES-1:0] != '0) begin
            // dsel is one-hot, so AND-OR muxing is exact.
            ready_s = |(dsel_r[NUM_SLAVES-1:0] & HREADYOUT_S);
            resp_s  = |(dsel_r[NUM_SLAVES-1:0] & HRESP_S);
            for (int i = 0; i < NUM_SLAVES; i++) begin
                rdata_s = rdata_s | ({DATA_W{dsel_r[i]}} & HRDATA_S[i*DATA_W +: DATA_W]);
            end
        end else begin
            ready_s = 1'b1;
            resp_s  = 1'b0;
        end
    end

    assign HRDATA = rdata_s;
    assign HREADY = ready_s;
    assign HRESP  = resp_s;

    // Data-phase select and default-slave state registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel_r  <= '0;
            state_r <= D_IDLE;
        end else begin
            state_r <= state_nxt_s;
            if (HREADY) begin
                dsel_r <= {def_sel_s, HSEL};
            end else begin
                dsel_r <= dsel_r;
            end
        end
    end

`ifdef DEC_ERR_LOG_EN
    logic [15:0]       err_count_r;
    logic [ADDR_W-1:0] err_addr_r;
    logic              err_load_s;

    // Entering D_ERR1 from anywhere else marks a newly accepted unmapped access.
    assign err_load_s = (state_nxt_s == D_ERR1) && (state_r != D_ERR1) && !HRESET;

    // Saturating error counter and address capture.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_count_r <= 16'h0000;
            err_addr_r  <= '0;
        end else if (err_load_s) begin
            err_addr_r <= HADDR;
            if (err_count_r != 16'hFFFF) begin
                err_count_r <= err_count_r + 16'h0001;
            end else begin
                err_count_r <= err_count_r;
            end
        end else begin
            err_count_r <= err_count_r;
            err_addr_r  <= err_addr_r;
        end
    end

    assign err_count = err_count_r;
    assign err_addr  = err_addr_r;
`endif

endmodule

// File: tb/tb_ahb_bus_decoder_mux.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ahb_bus_decoder_mux. Slot 3 is configured as a wide
// region (0x0xxx_xxxx) overlapping slot 0 so lowest-index priority is visible.
// A transaction-level reference model tracks the pending data-phase target
// and the error-phase count; every cycle's outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_ahb_bus_decoder_mux;

    localparam int N = 4;

    logic            HCLK;
    logic            HRESET;
    logic [31:0]     HADDR;
    logic [1:0]      HTRANS;
    logic [N-1:0]    HSEL;
    logic [N*32-1:0] HRDATA_S;
    logic [N-1:0]    HREADYOUT_S;
    logic [N-1:0]    HRESP_S;
    logic [31:0]     HRDATA;
    logic            HREADY;
    logic            HRESP;
`ifdef DEC_ERR_LOG_EN
    logic [15:0]     err_count;
    logic [31:0]     err_addr;
`endif

    ahb_bus_decoder_mux #(
        .NUM_SLAVES (N),
        .ADDR_W     (32),
        .DATA_W     (32),
        .SLV_BASE   ({32'h0000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK   ({32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000})
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSEL        (HSEL),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
`ifdef DEC_ERR_LOG_EN
        ,
        .err_count   (err_count),
        .err_addr    (err_addr)
`endif
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Reference regions (same map as the DUT parameters above).
    logic [31:0] m_base [N] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h0000_0000};
    logic [31:0] m_mask [N] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000};

    // Model state: pending target (-1 none, 0..N-1 slave, N default), error cycle number.
    int          m_tgt;
    int          m_phase;
    logic [15:0] m_cnt;
    logic [31:0] m_eaddr;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [N*32-1:0] FIXED_DATA = {32'hDDDD_0003, 32'hCCCC_0002,
                                              32'hBBBB_0001, 32'hAAAA_0000};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Target of the current address phase: lowest matching region, N if none, -1 if no transfer.
    function automatic int decode(input logic rst, input logic [1:0] tr, input logic [31:0] a);
        if (rst || !tr[1]) return -1;
        for (int i = 0; i < N; i++) begin
            if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
        end
        return N;
    endfunction

    function automatic logic exp_ready();
        if (m_tgt < 0) return 1'b1;
        if (m_tgt == N) return (m_phase == 2);
        return HREADYOUT_S[m_tgt];
    endfunction

    // Drive inputs on the falling edge, then compare all outputs with the model.
    task automatic drive(input logic rst, input logic [1:0] tr, input logic [31:0] a,
                         input logic [N-1:0] rdy, input logic [N-1:0] rsp);
        int          t;
        logic [N-1:0] eh;
        logic        ep;
        logic [31:0] ed;
        @(negedge HCLK);
        HRESET      = rst;
        HTRANS      = tr;
        HADDR       = a;
        HREADYOUT_S = rdy;
        HRESP_S     = rsp;
        #1;
        t  = decode(rst, tr, a);
        eh = (t >= 0 && t < N) ? (N'(1) << t) : '0;
        ep = 1'b0;
        ed = 32'h0;
        if (m_tgt == N) begin
            ep = 1'b1;
        end else if (m_tgt >= 0) begin
            ep = HRESP_S[m_tgt];
            ed = HRDATA_S[m_tgt*32 +: 32];
        end
        chk("hsel",   64'(HSEL),   64'(eh));
        chk("hready", 64'(HREADY), 64'(exp_ready()));
        chk("hresp",  64'(HRESP),  64'(ep));
        chk("hrdata", 64'(HRDATA), 64'(ed));
`ifdef DEC_ERR_LOG_EN
        chk("err_count", 64'(err_count), 64'(m_cnt));
        chk("err_addr",  64'(err_addr),  64'(m_eaddr));
`endif
    endtask

    // Advance one rising edge and update the model from the same inputs.
    task automatic tick();
        int t;
        @(posedge HCLK);
        if (HRESET) begin
            m_tgt   = -1;
            m_phase = 0;
            m_cnt   = 16'h0000;
            m_eaddr = 32'h0;
        end else if (exp_ready()) begin
            t = decode(1'b0, HTRANS, HADDR);
            if (t == N) begin
                m_phase = 1;
                m_eaddr = HADDR;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
            end
            m_tgt = t;
        end else if (m_tgt == N) begin
            m_phase = 2;
        end
    endtask

    typedef struct {
        logic [1:0]  tr;
        logic [31:0] addr;
        logic [N-1:0] exp_hsel;
    } vec_t;

    vec_t vecs [9];

    initial begin
        m_tgt = -1; m_phase = 0; m_cnt = 16'h0000; m_eaddr = 32'h0;
        HRESET = 1'b1; HTRANS = 2'b00; HADDR = 32'h0;
        HREADYOUT_S = '1; HRESP_S = '0; HRDATA_S = FIXED_DATA;

        vecs[0] = '{2'b10, 32'h1000_0040, 4'b0010};
        vecs[1] = '{2'b00, 32'h0000_0000, 4'b0000};
        vecs[2] = '{2'b01, 32'h1000_0000, 4'b0000};
        vecs[3] = '{2'b11, 32'h2000_FFFC, 4'b0100};
        vecs[4] = '{2'b10, 32'h0000_1234, 4'b0001};
        vecs[5] = '{2'b10, 32'h0800_0000, 4'b1000};
        vecs[6] = '{2'b10, 32'h8000_0000, 4'b0000};
        vecs[7] = '{2'b11, 32'h3000_0000, 4'b0000};
        vecs[8] = '{2'b10, 32'h1001_0000, 4'b0000};

        tick();
        tick();

        // Reset state.
        drive(1'b0, 2'b00, 32'h0, 4'hF, 4'h0);
        chk("rst_hready", 64'(HREADY), 64'h1);
        chk("rst_hresp",  64'(HRESP),  64'h0);
        chk("rst_hrdata", 64'(HRDATA), 64'h0);
        chk("rst_hsel",   64'(HSEL),   64'h0);
        tick();

        // Decode table.
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, vecs[i].tr, vecs[i].addr, 4'hF, 4'h0);
            chk("tbl_hsel", 64'(HSEL), 64'(vecs[i].exp_hsel));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 32'h0, 4'hF, 4'h0);
            tick();
        end

        // Decode + mux: slot 1 data and its HREADYOUT.
        drive(1'b0, 2'b10, 32'h1000_0040, 4'hF, 4'h0);
        chk("dm_hsel", 64'(HSEL), 64'h2);
        tick();
        drive(1'b0, 2'b00, 32'h0, 4'b1101, 4'h0);
        chk("dm_hrdata", 64'(HRDATA), 64'hBBBB_0001);
        chk("dm_hready", 64'(HREADY), 64'h0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 4'hF, 4'h0);
        chk("dm_hready_done", 64'(HREADY), 64'h1);
        tick();

        // IDLE gating.
        drive(1'b0, 2'b00, 32'h0, 4'hF, 4'h0);
        chk("idle_hsel", 64'(HSEL), 64'h0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 4'h0, 4'hF);
        chk("idle_phase", 64'({HREADY, HRESP}), 64'h2);
        chk("idle_hrdata", 64'(HRDATA), 64'h0);
        tick();

        // Unmapped: two-cycle error then idle.
        drive(1'b0, 2'b10, 32'h8000_0000, 4'hF, 4'h0);
        chk("um_hsel", 64'(HSEL), 64'h0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 4'hF, 4'h0);
        chk("um_err1", 64'({HREADY, HRESP}), 64'h1);
        tick();
        drive(1'b0, 2'b00, 32'h0, 4'hF, 4'h0);
        chk("um_err2", 64'({HREADY, HRESP}), 64'h3);
        tick();
        drive(1'b0, 2'b00, 32'h0, 4'hF, 4'h0);
        chk("um_idle", 64'({HREADY, HRESP}), 64'h2);
        tick();

        // Wait states on slave 2; next transfer to slave 0 held off until ready.
        drive(1'b0, 2'b10, 32'h2000_0010, 4'hF, 4'h0);
        chk("ws_hsel2", 64'(HSEL), 64'h4);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b10, 32'h0000_0100, 4'b1011, 4'h0);
            chk("ws_stall_hready", 64'(HREADY), 64'h0);
            chk("ws_stall_hsel", 64'(HSEL), 64'h1);
            chk("ws_stall_hrdata", 64'(HRDATA), 64'hCCCC_0002);
            tick();
        end
        drive(1'b0, 2'b10, 32'h0000_0100, 4'hF, 4'h0);
        chk("ws_release", 64'({HREADY, HRDATA}), {31'h0, 1'b1, 32'hCCCC_0002});
        tick();
        drive(1'b0, 2'b00, 32'h0, 4'b1110, 4'h0);
        chk("ws_slave0_hrdata", 64'(HRDATA), 64'hAAAA_0000);
        chk("ws_slave0_hready", 64'(HREADY), 64'h0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 4'hF, 4'h0);
        tick();

        // Reset during the first error cycle.
        drive(1'b0, 2'b10, 32'h8000_0000, 4'hF, 4'h0);
        tick();
        drive(1'b1, 2'b00, 32'h0, 4'hF, 4'h0);
        chk("rr_err1", 64'({HREADY, HRESP}), 64'h1);
        tick();
        drive(1'b0, 2'b00, 32'h0, 4'hF, 4'h0);
        chk("rr_after", 64'({HREADY, HRESP}), 64'h2);
        chk("rr_hrdata", 64'(HRDATA), 64'h0);
        tick();

        // Back-to-back unmapped accesses from a clean reset.
        drive(1'b1, 2'b00, 32'h0, 4'hF, 4'h0);
        tick();
        drive(1'b0, 2'b10, 32'h8000_0000, 4'hF, 4'h0);
        tick();
        drive(1'b0, 2'b10, 32'h9000_0004, 4'hF, 4'h0);
        chk("bb_1", 64'({HREADY, HRESP}), 64'h1);
        tick();
        drive(1'b0, 2'b10, 32'h9000_0004, 4'hF, 4'h0);
        chk("bb_2", 64'({HREADY, HRESP}), 64'h3);
        tick();
        drive(1'b0, 2'b00, 32'h0, 4'hF, 4'h0);
        chk("bb_3", 64'({HREADY, HRESP}), 64'h1);
        tick();
        drive(1'b0, 2'b00, 32'h0, 4'hF, 4'h0);
        chk("bb_4", 64'({HREADY, HRESP}), 64'h3);
`ifdef DEC_ERR_LOG_EN
        chk("bb_err_count", 64'(err_count), 64'h2);
        chk("bb_err_addr",  64'(err_addr),  64'h9000_0004);
`endif
        tick();

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [31:0] a;
            logic [15:0] lo;
            lo = 16'($urandom);
            case ($urandom_range(0, 5))
                0: a = {16'h0000, lo};
                1: a = {16'h1000, lo};
                2: a = {16'h2000, lo};
                3: a = {4'h0, 12'($urandom), lo};
                4: a = $urandom;
                default: a = {16'h3000, lo};
            endcase
            HRDATA_S = {$urandom, $urandom, $urandom, $urandom};
            drive(($urandom_range(0, 49) == 0), 2'($urandom),  a,
                  {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                  4'($urandom));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
